// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, forwarding selects, memory-wait freeze, flush gating and stall counters
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 4,
  parameter int MEM_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fwd_en,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] exe_src1,
  input  logic [REG_AW-1:0] exe_src2,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic              mem_req,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_wb_en,
  input  logic              branch_taken,
  output logic [1:0]        sel_src1,
  output logic [1:0]        sel_src2,
  output logic              hazard,
  output logic              freeze_if,
  output logic              bubble_id,
  output logic              hold_back,
  output logic              flush,
  output logic              mem_done,
  output logic [CNT_W-1:0]  hz_cnt,
  output logic [CNT_W-1:0]  mem_cnt
);
  localparam int WW = $clog2(MEM_WAIT + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [CNT_W-1:0] hz_cnt_q, hz_cnt_d, mem_cnt_q, mem_cnt_d;
  logic             last, stall_raw, haz_raw, mem_stall;
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] s, input logic [REG_AW-1:0] md,
                                         input logic me, input logic [REG_AW-1:0] wd, input logic we);
    return (me && md == s) ? 2'd1 : (we && wd == s) ? 2'd2 : 2'd0;
  endfunction
  function automatic logic match(input logic [REG_AW-1:0] d, input logic en, input logic [REG_AW-1:0] s1,
                                 input logic [REG_AW-1:0] s2, input logic two);
    return en && (d == s1 || (two && d == s2));
  endfunction
  always_comb begin
    last      = wcnt_q == WW'(MEM_WAIT - 1);
    stall_raw = mem_req && !last;
    haz_raw   = fwd_en ? match(exe_dest, exe_wb_en && exe_mem_r_en, id_src1, id_src2, id_two_src)
                       : match(exe_dest, exe_wb_en, id_src1, id_src2, id_two_src) ||
                         match(mem_dest, mem_wb_en, id_src1, id_src2, id_two_src);
    mem_stall = !rst && stall_raw;
    hazard    = !rst && haz_raw;
    sel_src1  = (rst || !fwd_en) ? 2'd0 : fwd_sel(exe_src1, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
    sel_src2  = (rst || !fwd_en) ? 2'd0 : fwd_sel(exe_src2, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
    mem_done  = !rst && mem_req && last;
    freeze_if = hazard || mem_stall;
    hold_back = mem_stall;
    bubble_id = hazard && !mem_stall;
    flush     = !rst && branch_taken && !mem_stall;
    state_d   = stall_raw ? BUSY : IDLE;
    wcnt_d    = !stall_raw ? '0 : (state_q == IDLE) ? WW'(1) : wcnt_q + 1'b1;
    hz_cnt_d  = (bubble_id && !(&hz_cnt_q)) ? hz_cnt_q + 1'b1 : hz_cnt_q;
    mem_cnt_d = (mem_stall && !(&mem_cnt_q)) ? mem_cnt_q + 1'b1 : mem_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      hz_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      hz_cnt_q  <= hz_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end
  assign hz_cnt  = hz_cnt_q;
  assign mem_cnt = mem_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with hand-computed expectations for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk, rst, fwd_en, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_req, wb_wb_en, branch_taken;
  logic [3:0] id_src1, id_src2, exe_src1, exe_src2, exe_dest, mem_dest, wb_dest;
  logic [1:0] sel_src1, sel_src2;
  logic hazard, freeze_if, bubble_id, hold_back, flush, mem_done;
  logic [3:0] hz_cnt, mem_cnt;
  int n_chk = 0, n_pass = 0;
  pipe_hazard_ctrl #(.REG_AW(4), .MEM_WAIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .branch_taken(branch_taken), .sel_src1(sel_src1),
    .sel_src2(sel_src2), .hazard(hazard), .freeze_if(freeze_if), .bubble_id(bubble_id),
    .hold_back(hold_back), .flush(flush), .mem_done(mem_done), .hz_cnt(hz_cnt), .mem_cnt(mem_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {fwd_en, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_req, wb_wb_en, branch_taken} = '0;
    {id_src1, id_src2, exe_src1, exe_src2, exe_dest, mem_dest, wb_dest} = '0;
  endtask
  initial begin
    clr();
    rst = 1'b1;
    fwd_en = 1'b1; exe_src1 = 4'd3; mem_dest = 4'd3; mem_wb_en = 1'b1; mem_req = 1'b1; branch_taken = 1'b1;
    tick(); tick();
    chk("rst_sel1", sel_src1, 0);
    chk("rst_hold", hold_back, 0);
    chk("rst_flush", flush, 0);
    chk("rst_hz_cnt", hz_cnt, 0);
    chk("rst_mem_cnt", mem_cnt, 0);
    clr();
    rst = 1'b0;
    // forwarding priority and zero register
    fwd_en = 1'b1; exe_src1 = 4'd3; mem_dest = 4'd3; mem_wb_en = 1'b1; wb_dest = 4'd3; wb_wb_en = 1'b1;
    #1 chk("fwd_mem", sel_src1, 1);
    chk("fwd_src2_none", sel_src2, 0);
    mem_wb_en = 1'b0;
    #1 chk("fwd_wb", sel_src1, 2);
    wb_dest = 4'd0;
    #1 chk("fwd_reg0", sel_src2, 2);
    fwd_en = 1'b0;
    #1 chk("fwd_off", sel_src2, 0);
    tick();
    // load-use hazard with forwarding on
    clr();
    fwd_en = 1'b1; id_src1 = 4'd5; exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    #1 chk("lu_hazard", hazard, 1);
    chk("lu_bubble", bubble_id, 1);
    chk("lu_freeze", freeze_if, 1);
    chk("lu_hold", hold_back, 0);
    tick();
    chk("lu_hz_cnt", hz_cnt, 1);
    exe_mem_r_en = 1'b0;
    #1 chk("alu_no_hazard", hazard, 0);
    tick();
    chk("alu_hz_cnt", hz_cnt, 1);
    // stall-only mode
    clr();
    id_src1 = 4'd1; id_two_src = 1'b1; id_src2 = 4'd7; mem_dest = 4'd7; mem_wb_en = 1'b1;
    #1 chk("so_hazard", hazard, 1);
    tick();
    chk("so_hz_cnt", hz_cnt, 2);
    id_two_src = 1'b0;
    #1 chk("so_one_src", hazard, 0);
    tick();
    chk("so_hz_cnt2", hz_cnt, 2);
    // two back-to-back accesses, branch raised during second stall cycle of the second
    clr();
    mem_req = 1'b1;
    for (int a = 0; a < 2; a++) begin
      for (int i = 0; i < 4; i++) begin
        if (a == 1 && i == 1) branch_taken = 1'b1;
        #1;
        chk($sformatf("mem_hold_a%0d_c%0d", a, i), hold_back, i < 3);
        chk($sformatf("mem_done_a%0d_c%0d", a, i), mem_done, i == 3);
        chk($sformatf("mem_frz_a%0d_c%0d", a, i), freeze_if, i < 3);
        if (a == 1) chk($sformatf("br_flush_c%0d", i), flush, (i == 3) ? 1 : 0);
        tick();
      end
      chk($sformatf("mem_cnt_a%0d", a), mem_cnt, 3 * (a + 1));
    end
    branch_taken = 1'b0;
    // reset in the middle of an access
    tick(); tick();
    rst = 1'b1;
    #1 chk("mrst_hold", hold_back, 0);
    chk("mrst_done", mem_done, 0);
    tick();
    chk("mrst_mem_cnt", mem_cnt, 0);
    chk("mrst_hz_cnt", hz_cnt, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("post_hold_c%0d", i), hold_back, i < 3);
      chk($sformatf("post_done_c%0d", i), mem_done, i == 3);
      tick();
    end
    chk("post_mem_cnt", mem_cnt, 3);
    // flush and hazard together, then saturation
    clr();
    fwd_en = 1'b1; id_src1 = 4'd5; exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; branch_taken = 1'b1;
    #1 chk("fh_flush", flush, 1);
    chk("fh_bubble", bubble_id, 1);
    branch_taken = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) chk("sat_hz_15", hz_cnt, 15);
    end
    chk("sat_hz_hold", hz_cnt, 15);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the 5-stage ARM core.
- Merges hazard detection and forwarding-select generation into one block, with a run-time forwarding on/off mode.
- Adds a multi-cycle memory-wait state machine that freezes the whole pipeline while a data-memory access completes.
- Adds branch-flush gating and saturating stall performance counters.
- Sits beside the stage registers and drives their freeze, flush and bubble controls, plus the EXE operand muxes.

Parameters:
- REG_AW, 4, register address width (16 architectural registers).
- MEM_WAIT, 4, cycles per data-memory access; minimum 1.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- fwd_en  in  1  forwarding mode: 1 = forward, 0 = stall-only.
- id_src1  in  REG_AW  Rn of the instruction in ID.
- id_src2  in  REG_AW  Rm/Rd of the instruction in ID.
- id_two_src  in  1  id_src2 is a real source.
- exe_src1, exe_src2  in  REG_AW each  sources of the instruction in EXE.
- exe_dest  in  REG_AW  destination of the instruction in EXE.
- exe_wb_en  in  1  write-back enable of the EXE instruction.
- exe_mem_r_en  in  1  memory-read enable of the EXE instruction.
- mem_dest  in  REG_AW  destination of the MEM-stage instruction.
- mem_wb_en  in  1  write-back enable of the MEM-stage instruction.
- mem_req  in  1  MEM-stage read or write enable.
- wb_dest  in  REG_AW  destination of the WB-stage instruction.
- wb_wb_en  in  1  write-back enable of the WB-stage instruction.
- branch_taken  in  1  branch resolved taken in EXE.
- sel_src1, sel_src2  out  2 each  operand select: 0 = register file, 1 = MEM result, 2 = WB result.
- hazard  out  1  data hazard detected on the ID instruction.
- freeze_if  out  1  hold PC and the IF/ID register.
- bubble_id  out  1  ID/EXE register loads a NOP.
- hold_back  out  1  hold the ID/EXE, EXE/MEM and MEM/WB registers.
- flush  out  1  flush the IF/ID and ID/EXE registers.
- mem_done  out  1  last cycle of a memory access.
- hz_cnt, mem_cnt  out  CNT_W each  hazard-stall and memory-stall cycle counters.

Behaviour:
- Reset (rst high at a clk edge): FSM to IDLE, wait counter 0, hz_cnt 0, mem_cnt 0.
- While rst is high, every combinational output is forced to 0.
- Forwarding (combinational), fwd_en=1:
  - sel_srcN = 1 if mem_wb_en and mem_dest == exe_srcN.
  - Otherwise sel_srcN = 2 if wb_wb_en and wb_dest == exe_srcN.
  - Otherwise sel_srcN = 0.
  - The MEM match takes priority over the WB match.
  - Register 0 is an ordinary register; there is no zero exclusion.
- Forwarding, fwd_en=0: sel_src1 = sel_src2 = 0.
- match(d, en) = en and (d == id_src1, or (id_two_src and d == id_src2)).
- Hazard, fwd_en=1: hazard = match(exe_dest, exe_wb_en and exe_mem_r_en). Only the load-use case stalls.
- Hazard, fwd_en=0: hazard = match(exe_dest, exe_wb_en) or match(mem_dest, mem_wb_en).
- Memory FSM, states IDLE and BUSY; wait counter wcnt is ceil(log2(MEM_WAIT+1)) bits wide:
  - last = (wcnt == MEM_WAIT-1).
  - mem_stall = mem_req and not last.
  - mem_done = mem_req and last.
  - IDLE with mem_req and not last: go to BUSY, wcnt = 1.
  - BUSY with mem_req and not last: wcnt increments.
  - Any state with last, or with mem_req low: go to IDLE, wcnt = 0.
  - MEM_WAIT=1: mem_stall never asserts, and mem_done = mem_req.
  - Back-to-back accesses: the next access starts at wcnt = 0 in the cycle after mem_done.
- Pipeline controls:
  - freeze_if = hazard or mem_stall.
  - hold_back = mem_stall.
  - bubble_id = hazard and not mem_stall.
  - flush = branch_taken and not mem_stall. A branch held during a memory stall flushes on the release cycle.
- Simultaneous flush and hazard: flush wins for IF/ID. bubble_id still asserts; the ID/EXE register gets a NOP either way.
- Counters: hz_cnt increments on cycles with bubble_id = 1. mem_cnt increments on cycles with mem_stall = 1. Both saturate at 2^CNT_W-1 and do not wrap.
- Reset mid-access: the FSM returns to IDLE. After reset, the access restarts with a full MEM_WAIT cycles.

Test Plan:
- fwd_en=1, exe_src1=3, mem_dest=3, mem_wb_en=1, wb_dest=3, wb_wb_en=1 -> sel_src1=1. Drop mem_wb_en -> sel_src1=2.
- fwd_en=1, id_src1=5, exe_dest=5, exe_wb_en=1, exe_mem_r_en=1 -> hazard=1, bubble_id=1, freeze_if=1, hz_cnt 0→1. Same with exe_mem_r_en=0 -> hazard=0.
- fwd_en=0, id_two_src=1, id_src2=7, mem_dest=7, mem_wb_en=1 -> hazard=1. Same with id_two_src=0 -> hazard=0.
- MEM_WAIT=4, mem_req held high -> mem_stall 1,1,1,0 and mem_done 0,0,0,1. mem_cnt = 3. Second access back-to-back repeats the same pattern.
- branch_taken=1 during the second stall cycle -> flush=0 until the mem_done cycle, then flush=1. rst pulsed mid-access -> outputs 0, FSM IDLE, next access takes a full 4 cycles.
- CNT_W=4, hazard held for 20 cycles -> hz_cnt stops at 15.
